uart_fifo_mmio: RTL and testbench
=================================

// Module: uart_fifo_mmio
// PURPOSE
//   Parametrised successor of the SoC UART peripheral. Memory-mapped 8N1 UART with TX/RX FIFOs,
//   runtime baud divisor, RX overrun detection and maskable level IRQ. Sits in the peripheral
//   block at base 0x8300; register index = i_addr[2:1] (word-aligned, +0x02 per register).
// PARAMETERS
//   CLK_FREQ      100_000_000  input clock frequency, Hz
//   BAUD_RATE     115200       reset baud; divisor reset value = (CLK_FREQ+BAUD_RATE/2)/BAUD_RATE
//   FIFO_DEPTH    8            entries per FIFO; power of two, >=2
//   DIV_W         16           width of BAUD divisor register
// PORTS
//   i_clk        in   1   system clock
//   i_rst        in   1   reset, asynchronous, active-low
//   i_sel        in   1   peripheral select
//   i_we         in   1   write strobe (qualified by i_sel)
//   i_re         in   1   read strobe (qualified by i_sel)
//   i_addr       in   16  byte address; bits [2:1] select register
//   i_wdata      in   16  write data
//   o_rdata      out  16  read data, combinational from i_addr; 0 when !(i_sel&i_re)
//   i_uart_rx    in   1   serial input, idle high, asynchronous
//   o_uart_tx    out  1   serial output, idle high
//   o_irq_req    out  1   level interrupt request
// BEHAVIOUR
//   Reset: o_uart_tx=1, o_irq_req=0, FIFOs empty, CTRL=0, STATUS flags 0, BAUD=reset divisor.
//   Registers: 0 DATA  W: push i_wdata[7:0] to TX FIFO (dropped if full). R: RX head in [7:0];
//                pop at the posedge of the read; empty -> reads 0x0000, no pop.
//              1 STATUS R: [0] tx_busy (shifter active or TX FIFO non-empty), [1] rx_pending (RX non-empty),
//                [2] tx_full, [3] rx_overrun, [4] parity_err. W: 1 to [1] flushes RX FIFO; 1 to [3]/[4] clears.
//              2 CTRL  [0] rx_irq_en, [1] tx_empty_irq_en, [2] parity_odd (used only with UART_PARITY_EN).
//              3 BAUD  cycles per bit, R/W; value <4 is clamped to 4. Write takes effect at next start bit.
//   TX: idle -> START -> DATA(8, LSB first) -> [PARITY] -> STOP -> idle; each state lasts BAUD cycles.
//       FIFO pop when entering START. Back-to-back bytes: no idle gap between STOP and next START.
//   RX: i_uart_rx via 2-FF synchroniser. Falling edge in idle starts BAUD counter; start bit re-checked
//       at BAUD/2 (high -> false start, back to idle). Data sampled at bit centres. Stop bit low ->
//       frame discarded, no push. Push on valid stop; RX full at push -> byte dropped, rx_overrun=1.
//   Simultaneous push/pop on same FIFO: both occur, count unchanged; pop on full RX plus push: no overrun.
//   Simultaneous DATA write to full TX and shifter pop: write accepted.
//   o_irq_req = (rx_irq_en & rx_pending) | (tx_empty_irq_en & !tx_busy) | rx_overrun; registered, 1-cycle.
//   Reset mid-frame: shifters abort, o_uart_tx to 1 asynchronously; partial RX frame discarded.
//   Counters: FIFO pointers log2(FIFO_DEPTH) bits wrapping; count register log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//   UART_PARITY_EN defined: one parity bit after data (even, odd if CTRL[2]); RX parity mismatch still
//     pushes byte and sets STATUS[4]. Undefined: 8N1 only, CTRL[2] and STATUS[4] read 0, no parity state.
// STRUCTURE
//   uart_pkg: register indices (REG_DATA..REG_BAUD), STATUS/CTRL bit positions, TX/RX state encodings,
//     default-divisor function.
//   Sub-module uart_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count; instantiated twice (TX, RX).
// TESTING
//   1 Write DATA=0x005A, BAUD=50 -> STATUS[0]=1 next cycle; o_uart_tx shows 0,0,1,0,1,1,0,1,0,1, 50 cycles/bit;
//     STATUS[0]=0 after stop bit.
//   2 Write 3 bytes 0x11,0x22,0x33 back-to-back -> three contiguous frames, no idle gap, order preserved.
//   3 Drive RX frame 0xA5 at BAUD=50 -> STATUS[1]=1; DATA read returns 0x00A5; STATUS[1]=0 afterwards.
//   4 Send FIFO_DEPTH+1 RX bytes without reading -> STATUS[3]=1, o_irq_req=1; reads return first
//     FIFO_DEPTH bytes; write STATUS=0x0008 clears overrun and IRQ.
//   5 CTRL=0x0001, 1-cycle low glitch on i_uart_rx -> no push, no IRQ; valid frame -> o_irq_req=1 until popped.
//   6 Assert i_rst mid-TX frame -> o_uart_tx=1 immediately, FIFOs empty, BAUD back to reset divisor.
//     With UART_PARITY_EN: RX 0x01 with even-parity bit 0 -> STATUS[4]=1, byte still readable.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS/CTRL bit
// positions, shifter state encodings and the reset baud divisor helper.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int unsigned ST_TX_BUSY = 0;
    localparam int unsigned ST_RX_PEND = 1;
    localparam int unsigned ST_TX_FULL = 2;
    localparam int unsigned ST_OVERRUN = 3;
    localparam int unsigned ST_PAR_ERR = 4;

    localparam int unsigned CT_RX_IE   = 0;
    localparam int unsigned CT_TXE_IE  = 1;
    localparam int unsigned CT_PAR_ODD = 2;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // Rounded clock cycles per bit for the reset baud rate.
    function automatic int unsigned default_div(int unsigned clk_freq, int unsigned baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush. A push into a full FIFO is accepted when a pop
// happens in the same cycle; pops on an empty FIFO are ignored.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_count = cnt_q;
    assign o_rdata = mem_q[rd_q];
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    // Storage array, no reset needed.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= i_wdata;
    end

    // Wrapping pointers and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (i_flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, RX overrun flag
// and a maskable level IRQ. Define UART_PARITY_EN for a parity bit after the
// data bits (even, or odd when CTRL[2] is set); otherwise frames are 8N1.
module uart_fifo_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_irq_req
);
    localparam logic [DIV_W-1:0] DivRst = DIV_W'(default_div(CLK_FREQ, BAUD_RATE));
`ifdef UART_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic [1:0] reg_idx;
    logic       wr_en, rd_en;
    logic [2:0] ctrl_q;
    logic [DIV_W-1:0] baud_q;
    logic       ovr_q, irq_q, par_err;
    logic       tx_push, tx_pop, tx_full, tx_empty, tx_busy, tx_tick;
    logic       rx_push, rx_pop, rx_full, rx_empty, rx_flush, rx_tick, rx_ovf;
    logic [7:0] tx_head, rx_head;
    logic [$clog2(FIFO_DEPTH):0] tx_count, rx_count;
    logic       unused_sig;

    tx_state_e        tx_st_q;
    logic [DIV_W-1:0] tx_cnt_q, tx_div_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_sh_q;
    logic             tx_q;

    rx_state_e        rx_st_q;
    logic [DIV_W-1:0] rx_cnt_q, rx_div_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_sh_q;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
`ifdef UART_PARITY_EN
    logic             tx_par_q, rx_par_bad_q, perr_q;
    assign par_err = perr_q;
`else
    assign par_err = 1'b0;
`endif

    assign reg_idx    = i_addr[2:1];
    assign wr_en      = i_sel & i_we;
    assign rd_en      = i_sel & i_re;
    assign unused_sig = ^{i_addr[15:3], i_addr[0], tx_count, rx_count};

    assign tx_push  = wr_en & (reg_idx == REG_DATA);
    assign tx_tick  = (tx_cnt_q == tx_div_q - DIV_W'(1));
    assign tx_pop   = ~tx_empty & ((tx_st_q == TxIdle) | ((tx_st_q == TxStop) & tx_tick));
    assign tx_busy  = (tx_st_q != TxIdle) | ~tx_empty;

    assign rx_tick  = (rx_cnt_q == rx_div_q - DIV_W'(1));
    assign rx_push  = (rx_st_q == RxStop) & rx_tick & rx_s2_q;
    assign rx_pop   = rd_en & (reg_idx == REG_DATA) & ~rx_empty;
    assign rx_flush = wr_en & (reg_idx == REG_STATUS) & i_wdata[ST_RX_PEND];
    assign rx_ovf   = rx_push & rx_full & ~rx_pop;

    assign o_uart_tx = tx_q;
    assign o_irq_req = irq_q;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(1'b0), .i_push(tx_push), .i_wdata(i_wdata[7:0]),
        .i_pop(tx_pop), .o_rdata(tx_head), .o_full(tx_full), .o_empty(tx_empty), .o_count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(rx_flush), .i_push(rx_push), .i_wdata(rx_sh_q),
        .i_pop(rx_pop), .o_rdata(rx_head), .o_full(rx_full), .o_empty(rx_empty), .o_count(rx_count)
    );

    // Register read mux; zero unless a selected read is in progress.
    always_comb begin
        o_rdata = '0;
        if (rd_en) begin
            unique case (reg_idx)
                REG_DATA:   o_rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
                REG_STATUS: o_rdata = {11'd0, par_err, ovr_q, tx_full, ~rx_empty, tx_busy};
                REG_CTRL:   o_rdata = {13'd0, ctrl_q};
                default:    o_rdata = 16'(baud_q);
            endcase
        end
    end

    // Control/status registers and the registered interrupt request.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ctrl_q <= '0;
            baud_q <= DivRst;
            ovr_q  <= 1'b0;
            irq_q  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            if (wr_en && reg_idx == REG_CTRL) ctrl_q <= {ParEn & i_wdata[2], i_wdata[1:0]};
            if (wr_en && reg_idx == REG_BAUD) begin
                baud_q <= (i_wdata[DIV_W-1:0] < DIV_W'(4)) ? DIV_W'(4) : i_wdata[DIV_W-1:0];
            end
            if (rx_ovf) ovr_q <= 1'b1;
            else if (wr_en && reg_idx == REG_STATUS && i_wdata[ST_OVERRUN]) ovr_q <= 1'b0;
`ifdef UART_PARITY_EN
            if (rx_push && rx_par_bad_q) perr_q <= 1'b1;
            else if (wr_en && reg_idx == REG_STATUS && i_wdata[ST_PAR_ERR]) perr_q <= 1'b0;
`endif
            irq_q <= (ctrl_q[CT_RX_IE] & ~rx_empty) | (ctrl_q[CT_TXE_IE] & ~tx_busy) | ovr_q;
        end
    end

    // TX shifter; the divisor is latched at each start bit so BAUD writes never split a frame.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_st_q  <= TxIdle;
            tx_cnt_q <= '0;
            tx_div_q <= DivRst;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_st_q  <= TxStart;
            tx_cnt_q <= '0;
            tx_div_q <= baud_q;
            tx_bit_q <= '0;
            tx_sh_q  <= tx_head;
            tx_q     <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q <= ^tx_head ^ ctrl_q[CT_PAR_ODD];
`endif
        end else if (tx_st_q != TxIdle) begin
            if (!tx_tick) begin
                tx_cnt_q <= tx_cnt_q + DIV_W'(1);
            end else begin
                tx_cnt_q <= '0;
                unique case (tx_st_q)
                    TxStart: begin
                        tx_st_q <= TxData;
                        tx_q    <= tx_sh_q[0];
                    end
                    TxData: begin
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_st_q <= TxParity;
                            tx_q    <= tx_par_q;
`else
                            tx_st_q <= TxStop;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_q     <= tx_sh_q[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    TxParity: begin
                        tx_st_q <= TxStop;
                        tx_q    <= 1'b1;
                    end
`endif
                    // End of stop bit with nothing queued.
                    default: begin
                        tx_st_q <= TxIdle;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    // RX synchroniser and deserialiser; samples are taken at bit centres after a half-bit start check.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= RxIdle;
            rx_cnt_q  <= '0;
            rx_div_q  <= DivRst;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= i_uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (rx_st_q == RxIdle) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_q  <= RxStart;
                    rx_cnt_q <= '0;
                    rx_div_q <= baud_q;
                end
            end else if (rx_st_q == RxStart) begin
                if (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1)) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= rx_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_q <= rx_cnt_q + DIV_W'(1);
                end
            end else if (!rx_tick) begin
                rx_cnt_q <= rx_cnt_q + DIV_W'(1);
            end else begin
                rx_cnt_q <= '0;
                unique case (rx_st_q)
                    RxData: begin
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                        if (rx_bit_q == 3'd7) rx_st_q <= RxParity;
`else
                        if (rx_bit_q == 3'd7) rx_st_q <= RxStop;
`endif
                    end
`ifdef UART_PARITY_EN
                    RxParity: begin
                        rx_par_bad_q <= rx_s2_q ^ (^rx_sh_q) ^ ctrl_q[CT_PAR_ODD];
                        rx_st_q      <= RxStop;
                    end
`endif
                    // Stop bit sampled; push (if high) is handled combinationally.
                    default: rx_st_q <= RxIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio: randomized bytes on both serial directions,
// compared against a frame/FIFO model derived from the register map and framing rules.
// Build with UART_PARITY_EN to include the parity bit in frames and the parity-error check.
module tb_uart_fifo_mmio;
    localparam int unsigned CLK_FREQ   = 100_000_000;
    localparam int unsigned BAUD_RATE  = 115200;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned RST_DIV    = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
`ifdef UART_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_BAUD = 2'd3;

    logic        i_clk = 1'b0, i_rst = 1'b1, i_sel = 1'b0, i_we = 1'b0, i_re = 1'b0;
    logic [15:0] i_addr = 16'h0, i_wdata = 16'h0, o_rdata;
    logic        i_uart_rx = 1'b1, o_uart_tx, o_irq_req;

    int          n_total = 0, n_bad = 0;
    int unsigned cyc = 0;
    logic        tx_prev = 1'b1;
    int unsigned fall_q[$];
    logic [7:0]  rx_model[$];
    bit          ovr_model = 1'b0;

    always #5 i_clk = ~i_clk;

    uart_fifo_mmio #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_sel), .i_we(i_we), .i_re(i_re), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_rdata(o_rdata), .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx),
        .o_irq_req(o_irq_req)
    );

    // Cycle counter plus a log of every falling edge on the TX line (cycle stamps).
    always @(posedge i_clk) begin
        #1;
        cyc++;
        if (tx_prev && !o_uart_tx) fall_q.push_back(cyc);
        tx_prev = o_uart_tx;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(int unsigned n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic wait_cyc(int unsigned t);
        while (cyc < t) tick(1);
    endtask

    task automatic bus_write(logic [1:0] idx, logic [15:0] d);
        i_sel = 1'b1; i_we = 1'b1; i_addr = 16'h8300 | {13'd0, idx, 1'b0}; i_wdata = d;
        tick(1);
        i_sel = 1'b0; i_we = 1'b0;
    endtask

    task automatic bus_read(logic [1:0] idx, output logic [15:0] d);
        i_sel = 1'b1; i_re = 1'b1; i_addr = 16'h8300 | {13'd0, idx, 1'b0};
        #1;
        d = o_rdata;
        tick(1);
        i_sel = 1'b0; i_re = 1'b0;
    endtask

    // Bit k of a serial frame: start, 8 data LSB first, [even parity], stop.
    function automatic logic frame_bit(logic [7:0] b, int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Checks contiguous TX frames near both ends of every bit, then that the transmitter went idle.
    task automatic check_tx(string tag, input logic [7:0] bytes[$], int unsigned baud);
        int unsigned t0, base;
        logic [15:0] d;
        for (int i = 0; i < 4000 && fall_q.size() == 0; i++) tick(1);
        check({tag, "_start_seen"}, 32'(fall_q.size() != 0), 1);
        if (fall_q.size() == 0) return;
        t0 = fall_q[0];
        for (int f = 0; f < bytes.size(); f++) begin
            for (int k = 0; k < FB; k++) begin
                base = t0 + (f * FB + k) * baud;
                wait_cyc(base + 1);
                check($sformatf("%s_f%0d_b%0d_early", tag, f, k), o_uart_tx, frame_bit(bytes[f], k));
                wait_cyc(base + baud - 2);
                check($sformatf("%s_f%0d_b%0d_late", tag, f, k), o_uart_tx, frame_bit(bytes[f], k));
            end
        end
        wait_cyc(t0 + bytes.size() * FB * baud + 2);
        bus_read(A_STAT, d);
        check({tag, "_busy_after"}, d[0], 0);
    endtask

    task automatic send_rx(logic [7:0] b, int unsigned baud, bit bad_par);
        logic v;
        for (int k = 0; k < FB; k++) begin
            v = frame_bit(b, k);
            if (bad_par && FB == 11 && k == 9) v = ~v;
            i_uart_rx = v;
            tick(baud);
        end
        i_uart_rx = 1'b1;
        tick(4);
    endtask

    function automatic void model_rx(logic [7:0] b);
        if (rx_model.size() < FIFO_DEPTH) rx_model.push_back(b);
        else ovr_model = 1'b1;
    endfunction

    initial begin
        logic [15:0] d;
        logic [7:0]  bytes[$];
        logic [7:0]  b;
        int unsigned baud;

        #2 i_rst = 1'b0;
        #20 i_rst = 1'b1;
        tick(2);

        // Reset state
        check("rst_tx", o_uart_tx, 1);
        check("rst_irq", o_irq_req, 0);
        #1 check("rdata_unselected", o_rdata, 0);
        bus_read(A_STAT, d); check("rst_status", d, 0);
        bus_read(A_CTRL, d); check("rst_ctrl", d, 0);
        bus_read(A_BAUD, d); check("rst_baud", d, RST_DIV);
        bus_read(A_DATA, d); check("rst_data_empty", d, 0);

        // BAUD clamp and readback
        bus_write(A_BAUD, 16'd2);
        bus_read(A_BAUD, d); check("baud_clamp", d, 4);
        bus_write(A_BAUD, 16'd50);
        bus_read(A_BAUD, d); check("baud_50", d, 50);

        // Single TX frame
        fall_q.delete();
        bus_write(A_DATA, 16'h005A);
        bus_read(A_STAT, d); check("tx_busy_set", d[0], 1);
        bytes.delete(); bytes.push_back(8'h5A);
        check_tx("tx1", bytes, 50);

        // Back-to-back TX frames with random data
        bytes.delete();
        for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom_range(0, 255)));
        tick(5);
        fall_q.delete();
        for (int i = 0; i < 3; i++) bus_write(A_DATA, {8'h00, bytes[i]});
        check_tx("tx3", bytes, 50);

        // Single RX frame
        send_rx(8'hA5, 50, 1'b0);
        model_rx(8'hA5);
        bus_read(A_STAT, d); check("rx_pending", d[1], 1);
        bus_read(A_DATA, d); check("rx_data", d, {8'h00, rx_model.pop_front()});
        bus_read(A_STAT, d); check("rx_pending_clr", d[1], 0);

        // RX overrun at a random divisor
        baud = $urandom_range(20, 60);
        bus_write(A_BAUD, 16'(baud));
        bus_read(A_BAUD, d); check("baud_rand", d, baud);
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            send_rx(b, baud, 1'b0);
            model_rx(b);
        end
        tick(2);
        bus_read(A_STAT, d); check("ovr_flag", d[3], 32'(ovr_model));
        check("ovr_irq", o_irq_req, 32'(ovr_model));
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus_read(A_DATA, d);
            check($sformatf("ovr_rd%0d", i), d, {8'h00, rx_model.pop_front()});
        end
        bus_read(A_DATA, d); check("ovr_rd_empty", d, 0);
        bus_write(A_STAT, 16'h0008);
        ovr_model = 1'b0;
        tick(2);
        bus_read(A_STAT, d); check("ovr_cleared", d[3], 0);
        check("ovr_irq_cleared", o_irq_req, 0);

        // Glitch rejection, then RX interrupt until popped
        bus_write(A_BAUD, 16'd50);
        bus_write(A_CTRL, 16'h0001);
        i_uart_rx = 1'b0; tick(1); i_uart_rx = 1'b1;
        tick(100);
        bus_read(A_STAT, d); check("glitch_no_push", d[1], 0);
        check("glitch_no_irq", o_irq_req, 0);
        b = 8'($urandom_range(0, 255));
        send_rx(b, 50, 1'b0);
        tick(2);
        check("rx_irq_set", o_irq_req, 1);
        bus_read(A_DATA, d); check("rx_irq_data", d, {8'h00, b});
        tick(2);
        check("rx_irq_clr", o_irq_req, 0);
        bus_write(A_CTRL, 16'h0000);

`ifdef UART_PARITY_EN
        // Parity error still delivers the byte
        send_rx(8'h01, 50, 1'b1);
        bus_read(A_STAT, d); check("par_err_set", d[4], 1);
        bus_read(A_DATA, d); check("par_err_data", d, 16'h0001);
        bus_write(A_STAT, 16'h0010);
        bus_read(A_STAT, d); check("par_err_clr", d[4], 0);
`endif

        // Reset in the middle of a TX frame
        fall_q.delete();
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 16'($urandom_range(0, 255)));
        for (int i = 0; i < 200 && fall_q.size() == 0; i++) tick(1);
        check("rst_mid_start_seen", 32'(fall_q.size() != 0), 1);
        if (fall_q.size() != 0) wait_cyc(fall_q[0] + 120);
        #3 i_rst = 1'b0;
        #1 check("rst_mid_tx", o_uart_tx, 1);
        check("rst_mid_irq", o_irq_req, 0);
        #3 i_rst = 1'b1;
        tick(2);
        fall_q.delete();
        tick(200);
        check("rst_mid_no_resume", fall_q.size(), 0);
        bus_read(A_STAT, d); check("rst_mid_status", d, 0);
        bus_read(A_BAUD, d); check("rst_mid_baud", d, RST_DIV);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
